// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and lamp constants for the NS/EW intersection controller.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } tl_state_e;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell counter: zero on the cycle a phase is entered, then counts up while it is held.
module tl_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] timer
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            timer <= '0;
        else
            timer <= timer + CNT_W'(1);
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with EW-sensor NS green extension.
// Build option TL_ALL_RED_EN inserts an all-red clearance phase after each yellow.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int GREEN_CYC     = 6,
    parameter int MAX_GREEN_CYC = 12,
    parameter int YELLOW_CYC    = 3,
    parameter int ALLRED_CYC    = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_ew,
    output logic [2:0]       ns,
    output logic [2:0]       ew,
    output tl_state_e        state,
    output logic [CNT_W-1:0] timer
);

    if (MAX_GREEN_CYC - 1 >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("traffic_light_ctrl: CNT_W too narrow for MAX_GREEN_CYC-1");
    end
    if (MAX_GREEN_CYC < GREEN_CYC || GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_bad_dwell
        $error("traffic_light_ctrl: illegal phase durations");
    end

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);

    tl_state_e next_state;
    logic      phase_change;

    always_ff @(posedge clk) begin
        if (rst)
            state <= NS_GREEN;
        else
            state <= next_state;
    end

    // Any phase change restarts the dwell count from zero.
    assign phase_change = (next_state != state);

    tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (phase_change),
        .timer (timer)
    );

    always_comb begin
        next_state = state;
        case (state)
            NS_GREEN:
                if ((timer >= G_LAST && car_ew) || timer == MAX_LAST)
                    next_state = NS_YELLOW;
            NS_YELLOW:
                if (timer == Y_LAST) begin
`ifdef TL_ALL_RED_EN
                    next_state = ALLRED_A;
`else
                    next_state = EW_GREEN;
`endif
                end
            ALLRED_A:
                if (timer == AR_LAST)
                    next_state = EW_GREEN;
            EW_GREEN:
                if (timer == G_LAST)
                    next_state = EW_YELLOW;
            EW_YELLOW:
                if (timer == Y_LAST) begin
`ifdef TL_ALL_RED_EN
                    next_state = ALLRED_B;
`else
                    next_state = NS_GREEN;
`endif
                end
            ALLRED_B:
                if (timer == AR_LAST)
                    next_state = NS_GREEN;
            default:
                next_state = NS_GREEN;
        endcase
    end

    // Red is the safe default so unused encodings never light a green.
    always_comb begin
        ns = LAMP_RED;
        ew = LAMP_RED;
        case (state)
            NS_GREEN:  ns = LAMP_GREEN;
            NS_YELLOW: ns = LAMP_YELLOW;
            EW_GREEN:  ew = LAMP_GREEN;
            EW_YELLOW: ew = LAMP_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random checks of traffic_light_ctrl with default durations; honours TL_ALL_RED_EN.
module tb_traffic_light_ctrl;
    import traffic_light_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       car_ew = 1'b0;
    logic [2:0] ns;
    logic [2:0] ew;
    tl_state_e  state;
    logic [3:0] timer;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int seen_ew = 0;
    bit mon_en  = 1'b0;

`ifdef TL_ALL_RED_EN
    localparam int T1_LAST   = 22;
    localparam int EW_T3_CYC = 14;
`else
    localparam int T1_LAST   = 18;
    localparam int EW_T3_CYC = 12;
`endif

    traffic_light_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .car_ew (car_ew),
        .ns     (ns),
        .ew     (ew),
        .state  (state),
        .timer  (timer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ns_lamp(input int s);
        case (s)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input int s);
        case (s)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int dwell(input int s);
        case (s)
            0:       return 12;
            1, 4:    return 3;
            3:       return 6;
            default: return 2;
        endcase
    endfunction

    // mode 0: car_ew held high; 1: never; 2: pulse at c3; 3: pulse at c8
    function automatic logic car_val(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            2:       return c == 3;
            3:       return c == 8;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_state(input int mode, input int c);
        if (mode == 0) begin
`ifdef TL_ALL_RED_EN
            if (c < 6)  return 0;
            if (c < 9)  return 1;
            if (c < 11) return 2;
            if (c < 17) return 3;
            if (c < 20) return 4;
            if (c < 22) return 5;
            return 0;
`else
            if (c < 6)  return 0;
            if (c < 9)  return 1;
            if (c < 15) return 3;
            if (c < 18) return 4;
            return 0;
`endif
        end
        if (mode == 3) return (c < 9) ? 0 : 1;
        return (c < 12) ? 0 : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        car_ew = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input int mode, input int last);
        int es;
        int prev;
        int et;
        do_reset();
        prev = -1;
        et = 0;
        for (int c = 0; c <= last; c++) begin
            es = exp_state(mode, c);
            et = (es == prev) ? et + 1 : 0;
            prev = es;
            chk($sformatf("%s c%0d state", tag, c), 32'(state), es);
            chk($sformatf("%s c%0d timer", tag, c), 32'(timer), et);
            chk($sformatf("%s c%0d ns", tag, c), 32'(ns), 32'(ns_lamp(es)));
            chk($sformatf("%s c%0d ew", tag, c), 32'(ew), 32'(ew_lamp(es)));
            car_ew = car_val(mode, c);
            step();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ns != 3'b100 && ew != 3'b100) viol++;
            if (int'(timer) >= dwell(int'(state))) viol++;
            if (state == EW_GREEN) seen_ew++;
        end
    end

    initial begin
        run("held", 0, T1_LAST);
        run("nocar", 1, 12);
        run("early_pulse", 2, 12);
        run("late_pulse", 3, 9);

        // reset in the middle of EW green
        do_reset();
        car_ew = 1'b1;
        for (int c = 0; c < EW_T3_CYC; c++) step();
        chk("midrst pre state", 32'(state), 3);
        chk("midrst pre timer", 32'(timer), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst state", 32'(state), 0);
        chk("midrst timer", 32'(timer), 0);
        chk("midrst ns", 32'(ns), 32'h1);
        chk("midrst ew", 32'(ew), 32'h4);
        step();
        chk("midrst hold timer", 32'(timer), 1);
        chk("midrst hold state", 32'(state), 0);

        // random sensor activity against the safety and dwell invariants
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            car_ew = ($urandom_range(0, 3) == 0);
            step();
        end
        mon_en = 1'b0;
        chk("random invariants", viol, 0);
        chk("random reached ew green", 32'(seen_ew > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
